dispatch_queue: RTL and testbench

- Dual-entry-wide in-order instruction buffer between decode and the dispatch stage.
- Accepts 0–2 decoded instructions per cycle and presents the two oldest entries, compacted, to dispatch.
- Retires 0, 1 or 2 entries per cycle according to the issue-enable mask dispatch returns (its `invalid_en` output).
- Producer side of the dispatch issue handshake.

---
 rtl/dispatch_queue.sv | 111 +++++++++++
 tb/tb_dispatch_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// In-order dual-wide instruction buffer between decode and dispatch.
// Accepts up to two instructions per cycle and presents the two oldest entries, compacted.
module dispatch_queue #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 93
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [1:0]           in_valid,
    input  logic [31:0]          in_pc0,
    input  logic [31:0]          in_pc1,
    input  logic [31:0]          in_inst0,
    input  logic [31:0]          in_inst1,
    input  logic [PAYLOAD_W-1:0] in_payload0,
    input  logic [PAYLOAD_W-1:0] in_payload1,
    output logic                 in_ready,
    output logic [1:0]           out_valid,
    output logic [31:0]          out_pc0,
    output logic [31:0]          out_pc1,
    output logic [31:0]          out_inst0,
    output logic [31:0]          out_inst1,
    output logic [PAYLOAD_W-1:0] out_payload0,
    output logic [PAYLOAD_W-1:0] out_payload1,
    input  logic [1:0]           issue_en,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_ptr, tail_ptr, head1, tail1;
    logic [CW-1:0] count, count_next;
    logic [1:0]    n_push, n_pop;
    logic          push_en, wr0, wr1, eff0, eff1;

    logic [31:0]          pc_mem      [DEPTH];
    logic [31:0]          inst_mem    [DEPTH];
    logic [PAYLOAD_W-1:0] payload_mem [DEPTH];

    // Handshake: an input slot transfers when its in_valid bit is set and
    // in_ready is high at the clock edge (flush low); in_ready depends only
    // on registered occupancy. An output slot retires when its out_valid bit
    // and issue_en bit are both set, and slot1 only together with slot0.
    assign in_ready = (count <= CW'(DEPTH - 2));
    assign push_en  = in_ready & ~flush;
    assign wr0      = push_en & (|in_valid);
    assign wr1      = push_en & (&in_valid);
    assign n_push   = push_en ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;

    assign head1 = head_ptr + AW'(1);
    assign tail1 = tail_ptr + AW'(1);

    assign out_valid[0] = (count != '0);
    assign out_valid[1] = (count >= CW'(2));

    assign eff0  = issue_en[0] & out_valid[0];
    assign eff1  = issue_en[1] & eff0 & out_valid[1];
    assign n_pop = {1'b0, eff0} + {1'b0, eff1};

    assign count_next = count + CW'(n_push) - CW'(n_pop);
    assign count_o    = count;

    always_comb begin
        out_pc0      = '0;
        out_inst0    = '0;
        out_payload0 = '0;
        out_pc1      = '0;
        out_inst1    = '0;
        out_payload1 = '0;
        if (out_valid[0]) begin
            out_pc0      = pc_mem[head_ptr];
            out_inst0    = inst_mem[head_ptr];
            out_payload0 = payload_mem[head_ptr];
        end
        if (out_valid[1]) begin
            out_pc1      = pc_mem[head1];
            out_inst1    = inst_mem[head1];
            out_payload1 = payload_mem[head1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + AW'(n_pop);
            tail_ptr <= tail_ptr + AW'(n_push);
            count    <= count_next;
        end
    end

    // A lone slot1 (in_valid=10) is compacted down into the tail entry.
    always_ff @(posedge clk) begin
        if (wr0) begin
            pc_mem[tail_ptr]      <= in_valid[0] ? in_pc0      : in_pc1;
            inst_mem[tail_ptr]    <= in_valid[0] ? in_inst0    : in_inst1;
            payload_mem[tail_ptr] <= in_valid[0] ? in_payload0 : in_payload1;
        end
        if (wr1) begin
            pc_mem[tail1]      <= in_pc1;
            inst_mem[tail1]    <= in_inst1;
            payload_mem[tail1] <= in_payload1;
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed table, hand sequences, and random traffic
// scored against a queue model of the buffer contents.
module tb_dispatch_queue;
    localparam int DEPTH = 8;
    localparam int PW    = 93;
    localparam int EW    = 64 + PW;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] BASE = 32'h1c00_0000;

    logic          clk, rst, flush, in_ready;
    logic [1:0]    in_valid, out_valid, issue_en;
    logic [31:0]   in_pc0, in_pc1, in_inst0, in_inst1;
    logic [31:0]   out_pc0, out_pc1, out_inst0, out_inst1;
    logic [PW-1:0] in_payload0, in_payload1, out_payload0, out_payload1;
    logic [CW-1:0] count_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Entry packed as {pc, inst, payload}, oldest at index 0.
    logic [EW-1:0] exp_q[$];

    dispatch_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_pc0(in_pc0), .in_pc1(in_pc1), .in_inst0(in_inst0), .in_inst1(in_inst1),
        .in_payload0(in_payload0), .in_payload1(in_payload1), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_payload0(out_payload0), .out_payload1(out_payload1),
        .issue_en(issue_en), .count_o(count_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        int sz;
        logic [EW-1:0] e0, e1;
        sz = exp_q.size();
        e0 = (sz >= 1) ? exp_q[0] : '0;
        e1 = (sz >= 2) ? exp_q[1] : '0;
        check("m_count", 160'(count_o), 160'(sz));
        check("m_ready", 160'(in_ready), 160'((DEPTH - sz) >= 2));
        check("m_valid", 160'(out_valid), 160'({sz >= 2, sz >= 1}));
        check("m_slot0", 160'({out_pc0, out_inst0, out_payload0}), 160'(e0));
        check("m_slot1", 160'({out_pc1, out_inst1, out_payload1}), 160'(e1));
    endtask

    // driver: apply one cycle of stimulus, advance the model, check after the edge
    task automatic step(input logic [1:0] iv, input logic [31:0] p0, input logic [31:0] p1,
                        input logic [1:0] ie, input logic fl);
        logic [EW-1:0] s0, s1;
        bit ready;
        int npop;
        in_valid    = iv;
        in_pc0      = p0;
        in_pc1      = p1;
        in_inst0    = $urandom;
        in_inst1    = $urandom;
        in_payload0 = PW'({$urandom, $urandom, $urandom});
        in_payload1 = PW'({$urandom, $urandom, $urandom});
        issue_en    = ie;
        flush       = fl;
        s0 = {p0, in_inst0, in_payload0};
        s1 = {p1, in_inst1, in_payload1};
        if (fl) begin
            exp_q.delete();
        end else begin
            ready = (DEPTH - exp_q.size()) >= 2;
            npop  = 0;
            if (ie[0] && exp_q.size() >= 1) npop = 1;
            if (ie == 2'b11 && exp_q.size() >= 2) npop = 2;
            repeat (npop) void'(exp_q.pop_front());
            if (ready) begin
                if (iv[0]) exp_q.push_back(s0);
                if (iv[1]) exp_q.push_back(s1);
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic [1:0]  iv;
        logic [1:0]  ie;
        logic        fl;
        logic [31:0] pc0;
        logic [31:0] pc1;
        int          e_cnt;
        logic [1:0]  e_valid;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
        logic        e_ready;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{2'b11, 2'b00, 1'b0, BASE + 32'h00, BASE + 32'h04, 2, 2'b11, BASE + 32'h00, BASE + 32'h04, 1'b1};
        vecs[1] = '{2'b10, 2'b01, 1'b0, 32'h0,         BASE + 32'h08, 2, 2'b11, BASE + 32'h04, BASE + 32'h08, 1'b1};
        vecs[2] = '{2'b00, 2'b11, 1'b0, 32'h0,         32'h0,         0, 2'b00, 32'h0,         32'h0,         1'b1};
        vecs[3] = '{2'b01, 2'b00, 1'b0, BASE + 32'h0c, 32'h0,         1, 2'b01, BASE + 32'h0c, 32'h0,         1'b1};
        vecs[4] = '{2'b00, 2'b11, 1'b0, 32'h0,         32'h0,         0, 2'b00, 32'h0,         32'h0,         1'b1};
        vecs[5] = '{2'b11, 2'b00, 1'b0, BASE + 32'h10, BASE + 32'h14, 2, 2'b11, BASE + 32'h10, BASE + 32'h14, 1'b1};
        vecs[6] = '{2'b00, 2'b10, 1'b0, 32'h0,         32'h0,         2, 2'b11, BASE + 32'h10, BASE + 32'h14, 1'b1};
        vecs[7] = '{2'b11, 2'b00, 1'b0, BASE + 32'h18, BASE + 32'h1c, 4, 2'b11, BASE + 32'h10, BASE + 32'h14, 1'b1};
        vecs[8] = '{2'b01, 2'b00, 1'b0, BASE + 32'h20, 32'h0,         5, 2'b11, BASE + 32'h10, BASE + 32'h14, 1'b1};
        vecs[9] = '{2'b11, 2'b11, 1'b1, BASE + 32'h24, BASE + 32'h28, 0, 2'b00, 32'h0,         32'h0,         1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = '0; issue_en = '0;
        in_pc0 = '0; in_pc1 = '0; in_inst0 = '0; in_inst1 = '0;
        in_payload0 = '0; in_payload1 = '0;
        #12;
        check("rst_valid", 160'(out_valid), 160'(2'b00));
        check("rst_ready", 160'(in_ready), 160'(1'b1));
        check("rst_count", 160'(count_o), 160'(0));
        check("rst_pc0",   160'(out_pc0), 160'(0));
        @(negedge clk);
        rst = 1'b0;

        // directed table
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].iv, vecs[i].pc0, vecs[i].pc1, vecs[i].ie, vecs[i].fl);
            check($sformatf("v%0d_count", i), 160'(count_o),  160'(vecs[i].e_cnt));
            check($sformatf("v%0d_valid", i), 160'(out_valid), 160'(vecs[i].e_valid));
            check($sformatf("v%0d_pc0", i),   160'(out_pc0),   160'(vecs[i].e_pc0));
            check($sformatf("v%0d_pc1", i),   160'(out_pc1),   160'(vecs[i].e_pc1));
            check($sformatf("v%0d_ready", i), 160'(in_ready),  160'(vecs[i].e_ready));
        end

        // fill to full, ignored push, drain in order
        for (int k = 0; k < 4; k++)
            step(2'b11, BASE + 32'(8 * k), BASE + 32'(8 * k + 4), 2'b00, 1'b0);
        check("full_count", 160'(count_o), 160'(8));
        check("full_ready", 160'(in_ready), 160'(1'b0));
        step(2'b11, 32'hdead_0000, 32'hdead_0004, 2'b00, 1'b0);
        check("full_ignore_count", 160'(count_o), 160'(8));
        check("full_ignore_pc0", 160'(out_pc0), 160'(BASE));
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain%0d_pc0", j), 160'(out_pc0), 160'(BASE + 32'(8 * j)));
            check($sformatf("drain%0d_pc1", j), 160'(out_pc1), 160'(BASE + 32'(8 * j + 4)));
            step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
            if (j == 0) check("ready_at_6", 160'(in_ready), 160'(1'b1));
        end

        // wrap the tail past the last index while popping
        for (int k = 0; k < 3; k++)
            step(2'b11, BASE + 32'h100 + 32'(8 * k), BASE + 32'h104 + 32'(8 * k), 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        for (int k = 0; k < 2; k++)
            step(2'b11, BASE + 32'h200 + 32'(8 * k), BASE + 32'h204 + 32'(8 * k), 2'b01, 1'b0);
        for (int k = 0; k < 4; k++)
            step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);

        // flush with count=5 and concurrent push/pop
        step(2'b11, BASE, BASE + 32'h4, 2'b00, 1'b0);
        step(2'b11, BASE + 32'h8, BASE + 32'hc, 2'b00, 1'b0);
        step(2'b01, BASE + 32'h10, 32'h0, 2'b00, 1'b0);
        check("pre_flush_count", 160'(count_o), 160'(5));
        step(2'b11, BASE + 32'h14, BASE + 32'h18, 2'b11, 1'b1);
        check("flush_count", 160'(count_o), 160'(0));
        check("flush_valid", 160'(out_valid), 160'(2'b00));

        // random traffic
        for (int c = 0; c < 400; c++) begin
            logic [1:0] ie;
            ie = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
            step(2'($urandom_range(0, 3)), $urandom, $urandom, ie, $urandom_range(0, 39) == 0);
        end

        // asynchronous reset between edges
        step(2'b11, BASE, BASE + 32'h4, 2'b00, 1'b0);
        step(2'b11, BASE + 32'h8, BASE + 32'hc, 2'b00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", 160'(count_o), 160'(0));
        check("async_rst_valid", 160'(out_valid), 160'(2'b00));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(2'b01, BASE + 32'h40, 32'h0, 2'b00, 1'b0);
        check("post_rst_pc0", 160'(out_pc0), 160'(BASE + 32'h40));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
